// File: rtl/usb_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_decoder
// Purpose  : USB receive front end. NRZI decode, SYNC detection, bit
//            unstuffing, LSB-first byte assembly and SE0-SE0-J EOP detection.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_decoder #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LEN    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_enable,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       EOP_flag,
  output logic       rx_error,
  output logic       receiving
);

  localparam int            OW      = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] C_STUFF = OW'(STUFF_LEN);
  localparam logic [OW-1:0] C_ONE   = OW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_EOP1 = 3'd3;
  localparam logic [2:0] S_EOP2 = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]    r_state, w_state_nx;
  logic          r_prev_j, n_prev_j;      // previous J/K symbol, 1 = J
  logic [3:0]    r_bit_cnt, n_bit_cnt;
  logic [OW-1:0] r_ones, n_ones;
  logic [7:0]    r_sync_sr, n_sync_sr;
  logic [7:0]    r_data_sr, n_data_sr;
  logic          r_err_se0, n_err_se0;    // in ERR: last sample was SE0
  logic [7:0]    n_rx_byte;
  logic          n_byte_valid, n_eop, n_rx_error, n_receiving;

  // Line symbol classification and NRZI decode against the previous J/K.
  wire       w_j    = d_plus & ~d_minus;
  wire       w_k    = ~d_plus & d_minus;
  wire       w_se0  = ~d_plus & ~d_minus;
  wire       w_se1  = d_plus & d_minus;
  wire       w_dbit = (w_j == r_prev_j);
  wire [7:0] w_sync_next = {w_dbit, r_sync_sr[7:1]};
  wire [7:0] w_data_next = {w_dbit, r_data_sr[7:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic, advanced only on a bit strobe.
  always_comb begin
    w_state_nx = r_state;
    if (shift_enable) begin
      case (r_state)
        S_IDLE: if (w_k) w_state_nx = S_SYNC;
        S_SYNC: begin
          if (w_se0 || w_se1)          w_state_nx = S_ERR;
          else if (r_bit_cnt == 4'd7)  w_state_nx = (w_sync_next == SYNC_PATTERN) ? S_DATA : S_ERR;
        end
        S_DATA: begin
          if (w_se0)                             w_state_nx = S_EOP1;
          else if (w_se1)                        w_state_nx = S_ERR;
          else if (r_ones == C_STUFF && w_dbit)  w_state_nx = S_ERR;
        end
        S_EOP1: w_state_nx = w_se0 ? S_EOP2 : S_ERR;
        S_EOP2: begin
          if (w_j)         w_state_nx = S_IDLE;
          else if (!w_se0) w_state_nx = S_ERR;
        end
        S_ERR:   if (w_j && r_err_se0) w_state_nx = S_IDLE;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    n_prev_j     = r_prev_j;
    n_bit_cnt    = r_bit_cnt;
    n_ones       = r_ones;
    n_sync_sr    = r_sync_sr;
    n_data_sr    = r_data_sr;
    n_err_se0    = r_err_se0;
    n_rx_byte    = rx_byte;
    n_byte_valid = 1'b0;
    n_eop        = 1'b0;
    n_rx_error   = rx_error;
    n_receiving  = receiving;
    if (shift_enable) begin
      if (w_j || w_k) n_prev_j = w_j;
      case (r_state)
        S_IDLE: begin
          if (w_k) begin
            n_bit_cnt   = 4'd1;
            n_ones      = '0;
            n_sync_sr   = w_sync_next;
            n_rx_error  = 1'b0;
            n_receiving = 1'b1;
          end
        end
        S_SYNC: begin
          if (w_state_nx == S_DATA) begin
            n_bit_cnt = 4'd0;
            n_ones    = C_ONE;   // trailing SYNC bit is a 1
          end else begin
            n_bit_cnt = r_bit_cnt + 4'd1;
            n_sync_sr = w_sync_next;
          end
        end
        S_DATA: begin
          if (w_se0) begin
            if (r_bit_cnt != 4'd0) n_rx_error = 1'b1;  // partial byte dropped
            n_bit_cnt = 4'd0;
          end else if (w_j || w_k) begin
            if (r_ones == C_STUFF) begin
              if (!w_dbit) n_ones = '0;              // stuffed 0 discarded
            end else begin
              n_data_sr = w_data_next;
              n_ones    = w_dbit ? r_ones + C_ONE : '0;
              if (r_bit_cnt == 4'd7) begin
                n_rx_byte    = w_data_next;
                n_byte_valid = 1'b1;
                n_bit_cnt    = 4'd0;
              end else begin
                n_bit_cnt = r_bit_cnt + 4'd1;
              end
            end
          end
        end
        S_EOP2: begin
          if (w_j) begin
            n_eop       = 1'b1;
            n_receiving = 1'b0;
          end
        end
        S_ERR:   n_err_se0 = w_se0;
        default: ;
      endcase
      if (w_state_nx == S_ERR && r_state != S_ERR) begin
        n_rx_error  = 1'b1;
        n_receiving = 1'b0;
        n_err_se0   = 1'b0;
      end
      if (w_state_nx == S_IDLE && r_state != S_IDLE) begin
        n_prev_j  = 1'b1;
        n_bit_cnt = 4'd0;
        n_ones    = '0;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_j   <= 1'b1;
      r_bit_cnt  <= 4'd0;
      r_ones     <= '0;
      r_sync_sr  <= 8'h00;
      r_data_sr  <= 8'h00;
      r_err_se0  <= 1'b0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      EOP_flag   <= 1'b0;
      rx_error   <= 1'b0;
      receiving  <= 1'b0;
    end else begin
      r_prev_j   <= n_prev_j;
      r_bit_cnt  <= n_bit_cnt;
      r_ones     <= n_ones;
      r_sync_sr  <= n_sync_sr;
      r_data_sr  <= n_data_sr;
      r_err_se0  <= n_err_se0;
      rx_byte    <= n_rx_byte;
      byte_valid <= n_byte_valid;
      EOP_flag   <= n_eop;
      rx_error   <= n_rx_error;
      receiving  <= n_receiving;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_decoder
// Purpose  : Directed self-checking bench for usb_rx_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_decoder;

  localparam logic [1:0] SYM_J   = 2'b10;
  localparam logic [1:0] SYM_K   = 2'b01;
  localparam logic [1:0] SYM_SE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       shift_enable = 1'b0;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic [7:0] rx_byte;
  logic       byte_valid, EOP_flag, rx_error, receiving;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int gap      = 1;     // clocks between strobes
  logic line   = 1'b1;  // current line level, 1 = J
  int tb_ones  = 0;

  // monitor state
  int         bv_cnt = 0, eop_cnt = 0, wide_cnt = 0, eop_rcv_bad = 0;
  logic [7:0] last_byte = 8'h00, prev_byte = 8'h00;
  logic       bv_d = 1'b0, eop_d = 1'b0;

  usb_rx_decoder dut (
    .clk(clk), .rst(rst), .shift_enable(shift_enable),
    .d_plus(d_plus), .d_minus(d_minus),
    .rx_byte(rx_byte), .byte_valid(byte_valid), .EOP_flag(EOP_flag),
    .rx_error(rx_error), .receiving(receiving)
  );

  always #5 clk = ~clk;

  // Collect pulses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt    <= bv_cnt + 1;
      prev_byte <= last_byte;
      last_byte <= rx_byte;
    end
    if (EOP_flag) eop_cnt <= eop_cnt + 1;
    if (EOP_flag && receiving) eop_rcv_bad <= eop_rcv_bad + 1;
    if ((byte_valid && bv_d) || (EOP_flag && eop_d)) wide_cnt <= wide_cnt + 1;
    bv_d  <= byte_valid;
    eop_d <= EOP_flag;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobed line sample, preceded by gap-1 idle clocks.
  task automatic sym(input logic [1:0] s);
    shift_enable = 1'b0;
    repeat (gap - 1) begin @(posedge clk); #1; end
    {d_plus, d_minus} = s;
    shift_enable = 1'b1;
    @(posedge clk); #1;
    shift_enable = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    if (!b) line = ~line;
    sym(line ? SYM_J : SYM_K);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    tb_ones = 1;
  endtask

  // LSB-first byte with USB bit stuffing after six 1s.
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      tb_ones = v[i] ? tb_ones + 1 : 0;
      if (tb_ones == 6) begin
        send_bit(1'b0);
        tb_ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    sym(SYM_SE0);
    sym(SYM_SE0);
    sym(SYM_J);
    line = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_byte", 32'(rx_byte), 32'h00);
    chk("rst_byte_valid", 32'(byte_valid), 0);
    chk("rst_eop", 32'(EOP_flag), 0);
    chk("rst_rx_error", 32'(rx_error), 0);
    chk("rst_receiving", 32'(receiving), 0);
    rst = 1'b0;

    // clean packet A5
    repeat (3) sym(SYM_J);
    send_bit(1'b0);
    chk("clean_rcv_first_k", 32'(receiving), 1);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    send_bit(1'b1);
    tb_ones = 1;
    send_byte(8'hA5);
    chk("clean_byte_valid_now", 32'(byte_valid), 1);
    chk("clean_rx_byte_now", 32'(rx_byte), 32'hA5);
    sym(SYM_SE0);
    chk("clean_rcv_in_eop", 32'(receiving), 1);
    sym(SYM_SE0);
    sym(SYM_J);
    line = 1'b1;
    chk("clean_eop_now", 32'(EOP_flag), 1);
    chk("clean_rcv_at_eop", 32'(receiving), 0);
    sym(SYM_J);
    chk("clean_eop_cleared", 32'(EOP_flag), 0);
    chk("clean_bv_cnt", 32'(bv_cnt), 1);
    chk("clean_eop_cnt", 32'(eop_cnt), 1);
    chk("clean_rx_error", 32'(rx_error), 0);

    // bit stuffing: FF then 00
    send_sync();
    send_byte(8'hFF);
    send_byte(8'h00);
    send_eop();
    sym(SYM_J);
    chk("stuff_bv_cnt", 32'(bv_cnt), 3);
    chk("stuff_byte1", 32'(prev_byte), 32'hFF);
    chk("stuff_byte2", 32'(last_byte), 32'h00);
    chk("stuff_rx_error", 32'(rx_error), 0);
    chk("stuff_eop_cnt", 32'(eop_cnt), 2);

    // stuff error: 1s without the stuffed 0
    send_sync();
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    chk("stufferr_rx_error", 32'(rx_error), 1);
    chk("stufferr_receiving", 32'(receiving), 0);
    send_bit(1'b1);
    send_eop();
    sym(SYM_J);
    chk("stufferr_no_eop", 32'(eop_cnt), 2);
    chk("stufferr_err_sticky", 32'(rx_error), 1);
    chk("stufferr_bv_cnt", 32'(bv_cnt), 3);

    // bad SYNC 0,0,0,0,0,1,0,1
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("badsync_rx_error", 32'(rx_error), 1);
    chk("badsync_receiving", 32'(receiving), 0);
    send_eop();
    sym(SYM_J);
    chk("badsync_bv_cnt", 32'(bv_cnt), 3);
    chk("badsync_no_eop", 32'(eop_cnt), 2);
    // following good packet
    send_bit(1'b0);
    chk("recover_err_clr", 32'(rx_error), 0);
    chk("recover_rcv", 32'(receiving), 1);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    send_bit(1'b1);
    tb_ones = 1;
    send_byte(8'h3C);
    send_eop();
    sym(SYM_J);
    chk("recover_bv_cnt", 32'(bv_cnt), 4);
    chk("recover_byte", 32'(last_byte), 32'h3C);
    chk("recover_eop_cnt", 32'(eop_cnt), 3);
    chk("recover_rx_error", 32'(rx_error), 0);

    // partial byte at EOP
    send_sync();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sym(SYM_SE0);
    chk("partial_err_now", 32'(rx_error), 1);
    sym(SYM_SE0);
    sym(SYM_J);
    line = 1'b1;
    sym(SYM_J);
    chk("partial_bv_cnt", 32'(bv_cnt), 4);
    chk("partial_eop_cnt", 32'(eop_cnt), 4);
    chk("partial_rx_error", 32'(rx_error), 1);

    // reset mid-byte
    send_sync();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rx_byte", 32'(rx_byte), 32'h00);
    chk("midrst_receiving", 32'(receiving), 0);
    chk("midrst_rx_error", 32'(rx_error), 0);
    chk("midrst_bv", 32'(byte_valid), 0);
    chk("midrst_eop", 32'(EOP_flag), 0);
    rst = 1'b0;
    line = 1'b1;
    repeat (3) sym(SYM_J);
    chk("midrst_no_eop", 32'(eop_cnt), 4);
    chk("midrst_no_bv", 32'(bv_cnt), 4);

    // strobe gaps of 4 and 7 clocks
    gap = 4;
    send_sync();
    send_byte(8'hA5);
    send_eop();
    sym(SYM_J);
    chk("gap4_bv_cnt", 32'(bv_cnt), 5);
    chk("gap4_byte", 32'(last_byte), 32'hA5);
    chk("gap4_eop_cnt", 32'(eop_cnt), 5);
    gap = 7;
    send_sync();
    send_byte(8'hA5);
    send_eop();
    sym(SYM_J);
    chk("gap7_bv_cnt", 32'(bv_cnt), 6);
    chk("gap7_byte", 32'(last_byte), 32'hA5);
    chk("gap7_eop_cnt", 32'(eop_cnt), 6);
    chk("gap7_rx_error", 32'(rx_error), 0);
    chk("pulse_width", 32'(wide_cnt), 0);
    chk("eop_rcv_overlap", 32'(eop_rcv_bad), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
`default_nettype wire
